// File: rtl/wb_dbus_pkg.sv
// Shared definitions for the dbus watchdog: FSM state encoding and Wishbone B3 cycle-type codes.
package wb_dbus_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWait  = 2'd1,
      StAbort = 2'd2,
      StHold  = 2'd3
   } wd_state_e;

   localparam logic [2:0] CtiClassic = 3'b000;
   localparam logic [2:0] CtiConst   = 3'b001;
   localparam logic [2:0] CtiIncr    = 3'b010;
   localparam logic [2:0] CtiEob     = 3'b111;

   // True when a response on this beat is followed by another strobed beat of the same burst.
   function automatic logic cti_continues(input logic [2:0] cti);
      case (cti)
         CtiConst, CtiIncr:  return 1'b1;
         CtiClassic, CtiEob: return 1'b0;
         default:            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/wb_dbus_wd_counter.sv
// Wait-state counter for the dbus watchdog: load to 1, clear, increment, and flag at TIMEOUT-1.
module wb_dbus_wd_counter
   import wb_dbus_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic load_i,
   input  logic inc_i,
   output logic term_o
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = CW'(1);
      end else if (inc_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_dbus_watchdog.sv
// Wishbone B3 dbus watchdog: aborts a beat left unanswered for TIMEOUT cycles with a one-cycle err.
// Define WB_DBUS_WATCHDOG_STATUS_EN to add last_to_adr_o / to_count_o abort status outputs.
module wb_dbus_watchdog
   import wb_dbus_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [AW-1:0]   wbm_adr_i,
   input  logic [DW-1:0]   wbm_dat_i,
   input  logic [DW/8-1:0] wbm_sel_i,
   input  logic            wbm_we_i,
   input  logic            wbm_cyc_i,
   input  logic            wbm_stb_i,
   input  logic [2:0]      wbm_cti_i,
   input  logic [1:0]      wbm_bte_i,
   output logic [DW-1:0]   wbm_dat_o,
   output logic            wbm_ack_o,
   output logic            wbm_err_o,
   output logic            wbm_rty_o,
   output logic [AW-1:0]   wbs_adr_o,
   output logic [DW-1:0]   wbs_dat_o,
   output logic [DW/8-1:0] wbs_sel_o,
   output logic            wbs_we_o,
   output logic            wbs_cyc_o,
   output logic            wbs_stb_o,
   output logic [2:0]      wbs_cti_o,
   output logic [1:0]      wbs_bte_o,
   input  logic [DW-1:0]   wbs_dat_i,
   input  logic            wbs_ack_i,
   input  logic            wbs_err_i,
   input  logic            wbs_rty_i,
   output logic            timeout_o
`ifdef WB_DBUS_WATCHDOG_STATUS_EN
   ,
   output logic [AW-1:0]   last_to_adr_o,
   output logic [15:0]     to_count_o
`endif
);

   wd_state_e state_q, state_d;
   logic      cnt_clr, cnt_load, cnt_inc, cnt_term;
   logic      slv_resp;

   assign slv_resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;

   assign wbs_adr_o = wbm_adr_i;
   assign wbs_dat_o = wbm_dat_i;
   assign wbs_sel_o = wbm_sel_i;
   assign wbs_we_o  = wbm_we_i;
   assign wbs_cti_o = wbm_cti_i;
   assign wbs_bte_o = wbm_bte_i;
   assign wbm_dat_o = wbs_dat_i;

   always_comb begin
      state_d   = state_q;
      cnt_clr   = 1'b0;
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
      wbs_cyc_o = wbm_cyc_i;
      wbs_stb_o = wbm_stb_i;
      wbm_ack_o = wbs_ack_i;
      wbm_err_o = wbs_err_i;
      wbm_rty_o = wbs_rty_i;
      timeout_o = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (wbm_cyc_i && wbm_stb_i && !slv_resp) begin
               state_d  = StWait;
               cnt_load = 1'b1;
            end
         end
         StWait: begin
            // A response beats the limit check, so a reply on the last allowed cycle is accepted.
            if (!wbm_cyc_i) begin
               state_d = StIdle;
               cnt_clr = 1'b1;
            end else if (slv_resp) begin
               cnt_clr = 1'b1;
               state_d = cti_continues(wbm_cti_i) ? StWait : StIdle;
            end else if (cnt_term) begin
               state_d = StAbort;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         StAbort: begin
            wbs_cyc_o = 1'b0;
            wbs_stb_o = 1'b0;
            wbm_ack_o = 1'b0;
            wbm_err_o = 1'b1;
            wbm_rty_o = 1'b0;
            timeout_o = 1'b1;
            state_d   = StHold;
         end
         StHold: begin
            wbs_cyc_o = 1'b0;
            wbs_stb_o = 1'b0;
            wbm_ack_o = 1'b0;
            wbm_err_o = 1'b0;
            wbm_rty_o = 1'b0;
            if (!wbm_cyc_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (wb_rst_i) begin
         wbs_cyc_o = 1'b0;
         wbs_stb_o = 1'b0;
         wbm_ack_o = 1'b0;
         wbm_err_o = 1'b0;
         wbm_rty_o = 1'b0;
         timeout_o = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   wb_dbus_wd_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_counter (
      .clk_i  (wb_clk_i),
      .rst_i  (wb_rst_i),
      .clr_i  (cnt_clr),
      .load_i (cnt_load),
      .inc_i  (cnt_inc),
      .term_o (cnt_term)
   );

`ifdef WB_DBUS_WATCHDOG_STATUS_EN
   logic [AW-1:0] last_to_adr_q;
   logic [15:0]   to_count_q;
   logic          abort_entry;

   assign abort_entry = (state_q == StWait) && (state_d == StAbort);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         last_to_adr_q <= '0;
         to_count_q    <= '0;
      end else if (abort_entry) begin
         last_to_adr_q <= wbm_adr_i;
         if (to_count_q != 16'hFFFF) begin
            to_count_q <= to_count_q + 16'd1;
         end
      end
   end

   assign last_to_adr_o = last_to_adr_q;
   assign to_count_o    = to_count_q;
`endif

endmodule

// File: tb/tb_wb_dbus_watchdog.sv
// Self-checking bench for wb_dbus_watchdog (TIMEOUT=16): deadline-based reference model plus directed checks.
module tb_wb_dbus_watchdog;
   import wb_dbus_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] m_adr = '0, m_dat = '0;
   logic [3:0]  m_sel = '0;
   logic        m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
   logic [2:0]  m_cti = '0;
   logic [1:0]  m_bte = '0;
   logic [31:0] s_dat = '0;
   logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

   logic [31:0] wbm_dat_o, wbs_adr_o, wbs_dat_o;
   logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
   logic [3:0]  wbs_sel_o;
   logic        wbs_we_o, wbs_cyc_o, wbs_stb_o, timeout_o;
   logic [2:0]  wbs_cti_o;
   logic [1:0]  wbs_bte_o;
`ifdef WB_DBUS_WATCHDOG_STATUS_EN
   logic [31:0] last_to_adr_o;
   logic [15:0] to_count_o;
`endif

   int n_cmp = 0, n_fail = 0;
   int to_pulses = 0, err_cnt = 0;

   always #5 clk = ~clk;

   wb_dbus_watchdog #(
      .AW (32), .DW (32), .TIMEOUT (TO)
   ) dut (
      .wb_clk_i  (clk),       .wb_rst_i  (rst),
      .wbm_adr_i (m_adr),     .wbm_dat_i (m_dat),     .wbm_sel_i (m_sel),
      .wbm_we_i  (m_we),      .wbm_cyc_i (m_cyc),     .wbm_stb_i (m_stb),
      .wbm_cti_i (m_cti),     .wbm_bte_i (m_bte),
      .wbm_dat_o (wbm_dat_o), .wbm_ack_o (wbm_ack_o), .wbm_err_o (wbm_err_o),
      .wbm_rty_o (wbm_rty_o),
      .wbs_adr_o (wbs_adr_o), .wbs_dat_o (wbs_dat_o), .wbs_sel_o (wbs_sel_o),
      .wbs_we_o  (wbs_we_o),  .wbs_cyc_o (wbs_cyc_o), .wbs_stb_o (wbs_stb_o),
      .wbs_cti_o (wbs_cti_o), .wbs_bte_o (wbs_bte_o),
      .wbs_dat_i (s_dat),     .wbs_ack_i (s_ack),     .wbs_err_i (s_err),
      .wbs_rty_i (s_rty),
      .timeout_o (timeout_o)
`ifdef WB_DBUS_WATCHDOG_STATUS_EN
      ,
      .last_to_adr_o (last_to_adr_o),
      .to_count_o    (to_count_o)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a watched beat has a deadline TO cycles after it starts; the err cycle is
   // the deadline itself, after which the master sees nothing until it drops cyc.
   int  cyc_n    = 0;
   bit  watching = 1'b0;
   bit  blocked  = 1'b0;
   int  deadline = 0;
   int  abort_at = -1;

   always @(negedge clk) begin
      logic [5:0] exp_ctl;
      logic       resp;
      resp = s_ack | s_err | s_rty;
      if (timeout_o) to_pulses++;
      if (wbm_err_o) err_cnt++;
      if (rst) begin
         exp_ctl  = 6'b0;
         watching = 1'b0;
         blocked  = 1'b0;
         abort_at = -1;
      end else if (abort_at == cyc_n) begin
         exp_ctl  = 6'b000101;
         abort_at = -1;
         blocked  = 1'b1;
      end else if (blocked) begin
         exp_ctl  = 6'b0;
         blocked  = m_cyc;
      end else begin
         exp_ctl = {m_cyc, m_stb, s_ack, s_err, s_rty, 1'b0};
         if (watching && !m_cyc) begin
            watching = 1'b0;
         end else if (watching && resp) begin
            if (m_cti == CtiIncr || m_cti == CtiConst) deadline = cyc_n + 1 + TO;
            else watching = 1'b0;
         end else if (!watching && m_cyc && m_stb && !resp) begin
            watching = 1'b1;
            deadline = cyc_n + TO;
         end
         if (watching && m_cyc && !resp && cyc_n + 1 == deadline) begin
            abort_at = deadline;
            watching = 1'b0;
         end
      end
      check("ctl", 64'({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}),
            64'(exp_ctl));
      check("pass_adr_dat", {wbs_adr_o, wbs_dat_o}, {m_adr, m_dat});
      check("pass_misc", 64'({wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbm_dat_o}),
            64'({m_sel, m_we, m_cti, m_bte, s_dat}));
      cyc_n++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [31:0] adr, input logic [2:0] cti);
      m_cyc = 1'b1; m_stb = 1'b1; m_adr = adr; m_cti = cti;
      m_we = 1'b0; m_sel = 4'hF; m_dat = ~adr; m_bte = 2'b00;
   endtask

   task automatic release_bus();
      m_cyc = 1'b0; m_stb = 1'b0; m_cti = CtiClassic;
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
   endtask

   task automatic read_acked(input string name, input logic [31:0] adr, input int wait_n,
                             input logic [31:0] dat);
      step();
      go(adr, CtiClassic);
      for (int k = 1; k <= wait_n; k++) begin
         step();
         #1;
         check({name, "_noack"}, 64'(wbm_ack_o), 64'd0);
      end
      s_ack = 1'b1; s_dat = dat;
      #1;
      check({name, "_ack"}, 64'(wbm_ack_o), 64'd1);
      check({name, "_dat"}, 64'(wbm_dat_o), 64'(dat));
      check({name, "_err"}, 64'(wbm_err_o), 64'd0);
      step();
      release_bus();
   endtask

   task automatic timeout_access(input string name, input logic [31:0] adr, output int lat);
      step();
      go(adr, CtiClassic);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         #1;
         if (wbm_err_o && lat < 0) begin
            lat = k;
            check({name, "_cyc_low"}, 64'(wbs_cyc_o), 64'd0);
            check({name, "_to_pulse"}, 64'(timeout_o), 64'd1);
         end
      end
      check({name, "_hold_err"}, 64'(wbm_err_o), 64'd0);
      release_bus();
      step();
   endtask

   initial begin
      int lat, p0, e0, acks;
      #50000;
      $display("FAIL global_time_limit reached: got running expected finished");
      $fatal(1);
   end

   initial begin
      int lat, p0, e0, acks;
      repeat (2) step();
      rst = 1'b0;

      // Zero-wait slave and rty pass-through.
      read_acked("t0", 32'h1000_0000, 0, 32'h1234_5678);
      step();
      go(32'h1000_0008, CtiClassic);
      s_rty = 1'b1;
      #1;
      check("t0_rty", 64'(wbm_rty_o), 64'd1);
      step();
      release_bus();

      // Single read acked after 3 cycles.
      p0 = to_pulses;
      read_acked("t1", 32'h1000_0004, 3, 32'hDEAD_BEEF);
      step();
      check("t1_no_timeout", 64'(to_pulses - p0), 64'd0);

      // Silent slave: err exactly TO cycles after stb, one timeout pulse.
      p0 = to_pulses;
      timeout_access("t2", 32'h9000_0000, lat);
      check("t2_latency", 64'(lat), 64'd16);
      check("t2_pulses", 64'(to_pulses - p0), 64'd1);
      read_acked("t2_after", 32'h1000_0010, 1, 32'h0BAD_F00D);

      // INCR burst, 4 beats, each acked after 12 cycles.
      e0 = err_cnt;
      acks = 0;
      step();
      go(32'h2000_0000, CtiIncr);
      for (int b = 0; b < 4; b++) begin
         for (int k = 1; k <= 12; k++) step();
         s_ack = 1'b1; s_dat = 32'hB000_0000 + 32'(b);
         #1;
         if (wbm_ack_o) acks++;
         step();
         s_ack = 1'b0;
         if (b < 3) begin
            m_adr = m_adr + 32'd4;
            m_cti = (b == 2) ? CtiEob : CtiIncr;
         end else begin
            release_bus();
         end
      end
      check("t3_acks", 64'(acks), 64'd4);
      check("t3_no_err", 64'(err_cnt - e0), 64'd0);

      // Ack on the last allowed cycle wins over the limit.
      e0 = err_cnt; p0 = to_pulses;
      read_acked("t4", 32'h3000_0000, TO - 1, 32'hCAFE_0001);
      repeat (3) step();
      check("t4_no_err", 64'(err_cnt - e0), 64'd0);
      check("t4_no_to", 64'(to_pulses - p0), 64'd0);

      // Master abandons a waiting cycle, then a fresh access works.
      step();
      go(32'h3000_0100, CtiClassic);
      repeat (5) step();
      release_bus();
      read_acked("t4b", 32'h3000_0104, 14, 32'hCAFE_0002);

      // Reset while waiting at count 10.
      e0 = err_cnt;
      step();
      go(32'h4000_0000, CtiClassic);
      repeat (10) step();
      rst = 1'b1;
      #1;
      check("t5_rst_cyc", 64'(wbs_cyc_o), 64'd0);
      check("t5_rst_err", 64'(wbm_err_o), 64'd0);
      step();
      rst = 1'b0;
      release_bus();
      read_acked("t5_fresh", 32'h4000_0004, 14, 32'h5555_AAAA);
      check("t5_no_err", 64'(err_cnt - e0), 64'd0);

`ifdef WB_DBUS_WATCHDOG_STATUS_EN
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("t6_cnt_rst", 64'(to_count_o), 64'd0);
      timeout_access("t6a", 32'h9000_0000, lat);
      timeout_access("t6b", 32'hA000_0004, lat);
      check("t6_last_adr", 64'(last_to_adr_o), 64'hA000_0004);
      check("t6_count", 64'(to_count_o), 64'd2);
`endif

      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
